rv32_mod_muldiv: RTL

Iterative RV32M multiply/divide unit in the execute stage, beside rv32_mod_alu. It takes the same register-file operands (read0_data, read1_data).
- Its result feeds the same writeback mux as the ALU result.
- It asserts stall so the pipeline holds while a multi-cycle op runs.
- Radix-2: one shift-add or restoring-subtract step per cycle, then one sign-fix cycle.

---
 rtl/rv32_pkg.sv | 39 +++
 rtl/rv32_mod_divu_step.sv | 27 ++
 rtl/rv32_mod_muldiv.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types and constants for the RV32 execute-stage units.
//   muldiv_op_e    : RV32M funct3 encodings
//   muldiv_state_e : multiply/divide sequencer states
//   MULDIV_ITER, DIV0_QUOT, INT_MIN : iteration count and special-case results
package rv32_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    localparam int          MULDIV_ITER = 32;
    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN     = 32'h8000_0000;

    function automatic logic md_rs1_signed(muldiv_op_e op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_rs2_signed(muldiv_op_e op);
        return (op == MD_MUL) || (op == MD_MULH) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/rv32_mod_divu_step.sv
// rv32_mod_divu_step: one combinational restoring-division step.
//   rem_in       : current partial remainder (XLEN+1 bits)
//   dividend_bit : next dividend bit shifted in at the bottom
//   divisor      : unsigned divisor magnitude
//   rem_out      : next partial remainder
//   quot_bit     : quotient bit produced by this step
module rv32_mod_divu_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic            quot_bit
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {2'b00, divisor};

    // Non-negative difference means the divisor fits: keep it and emit a 1.
    assign quot_bit = ~diff[XLEN+1];
    assign rem_out  = quot_bit ? diff[XLEN:0] : shifted[XLEN:0];

endmodule

// File: rtl/rv32_mod_muldiv.sv
// rv32_mod_muldiv: iterative radix-2 RV32M multiply/divide unit.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, flush          : request (sampled in IDLE/DONE), synchronous kill
//   func                  : funct3 operation select
//   read0_data/read1_data : rs1/rs2 operands
//   result, done          : registered result, one-cycle valid pulse
//   stall                 : pipeline hold request (combinational)
// Optional: define RV32_MULDIV_FAST_MUL_EN for a single-cycle multiplier;
// divides always use the 32-step iterative path.
module rv32_mod_muldiv
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func,
    input  logic [XLEN-1:0] read0_data,
    input  logic [XLEN-1:0] read1_data,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            stall
);

    localparam int CNT_W = $clog2(MULDIV_ITER);

    function automatic logic [2*XLEN-1:0] cond_neg64(logic [2*XLEN-1:0] v, logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] cond_neg32(logic [XLEN-1:0] v, logic en);
        return en ? -v : v;
    endfunction

    muldiv_state_e state_q, state_d;
    muldiv_op_e    op_in, op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  opa_q, opb_q, lo_q, result_q;
    logic [XLEN:0]    hi_q;
    logic             neg_q;

    logic            rs1_neg, rs2_neg, res_neg, op_is_div;
    logic [XLEN-1:0] rs1_mag, rs2_mag;
    logic            div0, ovf, fast_mul, fast_path, can_accept, accept;
    logic [XLEN-1:0] fast_res, fast_mul_res, fix_res;
    logic [XLEN:0]   mul_sum, div_rem, hi_next;
    logic [XLEN-1:0] lo_next;
    logic            div_q;
    logic [2*XLEN-1:0] prod_fixed;

    assign op_in     = muldiv_op_e'(func);
    assign op_is_div = func[2];
    assign rs1_neg   = md_rs1_signed(op_in) & read0_data[XLEN-1];
    assign rs2_neg   = md_rs2_signed(op_in) & read1_data[XLEN-1];
    assign rs1_mag   = rs1_neg ? -read0_data : read0_data;
    assign rs2_mag   = rs2_neg ? -read1_data : read1_data;
    // Remainder takes the dividend sign; everything else is the XOR of signs.
    assign res_neg   = (op_in == MD_REM) ? rs1_neg : (rs1_neg ^ rs2_neg);

    assign div0 = op_is_div && (read1_data == '0);
    assign ovf  = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                  (read0_data == INT_MIN) && (read1_data == DIV0_QUOT);

`ifdef RV32_MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fm_a, fm_b;
    logic signed [2*XLEN-1:0] fm_prod;
    assign fm_a    = {md_rs1_signed(op_in) & read0_data[XLEN-1], read0_data};
    assign fm_b    = {md_rs2_signed(op_in) & read1_data[XLEN-1], read1_data};
    // Low 2*XLEN bits of the 33x33 product are exact for every MUL* variant.
    assign fm_prod = (2*XLEN)'(fm_a * fm_b);
    assign fast_mul     = !op_is_div;
    assign fast_mul_res = (op_in == MD_MUL) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
`else
    assign fast_mul     = 1'b0;
    assign fast_mul_res = '0;
`endif

    assign fast_path = div0 || ovf || fast_mul;

    always_comb begin
        fast_res = fast_mul_res;
        if (div0) begin
            fast_res = func[1] ? read0_data : DIV0_QUOT;
        end else if (ovf) begin
            fast_res = func[1] ? '0 : INT_MIN;
        end
    end

    assign can_accept = (state_q == IDLE) || (state_q == DONE);
    assign accept     = start && can_accept && !flush;
    assign stall      = (state_q == RUN) || (state_q == FIX) ||
                        (start && can_accept && !fast_path);
    assign done       = (state_q == DONE);
    assign result     = result_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = accept ? (fast_path ? DONE : RUN) : IDLE;
            RUN:        if (cnt_q == '0) state_d = FIX;
            FIX:        state_d = DONE;
            default:    state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    rv32_mod_divu_step #(.XLEN(XLEN)) u_divu_step (
        .rem_in       (hi_q),
        .dividend_bit (lo_q[XLEN-1]),
        .divisor      (opb_q),
        .rem_out      (div_rem),
        .quot_bit     (div_q)
    );

    // Multiply: {hi,lo} shifts right, multiplier bits leave lo[0] while product
    // bits enter at the top. Divide: dividend leaves lo[MSB], quotient enters lo[0].
    always_comb begin
        mul_sum = {1'b0, hi_q[XLEN-1:0]} + (lo_q[0] ? {1'b0, opa_q} : '0);
        if (op_q[2]) begin
            hi_next = div_rem;
            lo_next = {lo_q[XLEN-2:0], div_q};
        end else begin
            hi_next = {1'b0, mul_sum[XLEN:1]};
            lo_next = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    assign prod_fixed = cond_neg64({hi_q[XLEN-1:0], lo_q}, neg_q);

    always_comb begin
        case (op_q)
            MD_MUL:                       fix_res = prod_fixed[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_fixed[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_res = cond_neg32(lo_q, neg_q);
            default:                      fix_res = cond_neg32(hi_q[XLEN-1:0], neg_q);
        endcase
    end

    // Operand latch / iteration / sign-fix datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MD_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q  <= op_in;
            neg_q <= res_neg;
            cnt_q <= CNT_W'(MULDIV_ITER - 1);
            opa_q <= rs1_mag;
            opb_q <= rs2_mag;
            hi_q  <= '0;
            lo_q  <= op_is_div ? rs1_mag : rs2_mag;
            if (fast_path) result_q <= fast_res;
        end else if (!flush && state_q == RUN) begin
            cnt_q <= cnt_q - 1'b1;
            hi_q  <= hi_next;
            lo_q  <= lo_next;
        end else if (!flush && state_q == FIX) begin
            result_q <= fix_res;
        end
    end

endmodule
